// File: rtl/food_placer.sv
// Food placement FSM: random draws checked against snake occupancy, with an optional
// row-major fallback scan enabled by FOOD_PLACER_SCAN_FALLBACK_EN.
module food_placer #(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       place_req,
    input  logic [3:0] rng4,
    input  logic [4:0] rng5,
    output logic       rng_update,
    output logic       occ_valid,
    output logic [4:0] occ_x,
    output logic [3:0] occ_y,
    input  logic       occ_ready,
    input  logic       occ_hit,
    output logic [4:0] food_x,
    output logic [3:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       fail
);

    localparam logic [5:0] W_LIM   = 6'(GRID_W);
    localparam logic [4:0] H_LIM   = 5'(GRID_H);
    localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    localparam logic [4:0] X_LAST = 5'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, SCAN} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAW, CHECK} state_t;
`endif

    state_t     r_state, w_state_nxt;
    logic [4:0] r_cand_x, w_cand_x;
    logic [3:0] r_cand_y, w_cand_y;
    logic [3:0] r_tries, w_tries;
    logic [4:0] r_food_x, w_food_x;
    logic [3:0] r_food_y, w_food_y;
    logic       r_food_valid, w_food_valid;
    logic       r_fail, w_fail;
    logic       w_exhaust;
    logic       w_in_range;
    logic [3:0] w_tries_inc;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    logic [4:0] r_scan_x, w_scan_x;
    logic [3:0] r_scan_y, w_scan_y;
`endif

    assign w_in_range  = ({1'b0, rng5} < W_LIM) && ({1'b0, rng4} < H_LIM);
    assign w_tries_inc = r_tries + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_x     = r_cand_x;
        w_cand_y     = r_cand_y;
        w_tries      = r_tries;
        w_food_x     = r_food_x;
        w_food_y     = r_food_y;
        w_food_valid = r_food_valid;
        w_fail       = 1'b0;
        w_exhaust    = 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        w_scan_x     = r_scan_x;
        w_scan_y     = r_scan_y;
`endif
        case (r_state)
            IDLE: begin
                if (place_req) begin
                    w_state_nxt  = DRAW;
                    w_food_valid = 1'b0;
                    w_tries      = '0;
                end
            end
            DRAW: begin
                w_cand_x = rng5;
                w_cand_y = rng4;
                w_tries  = w_tries_inc;
                if (w_in_range)
                    w_state_nxt = CHECK;
                else if (w_tries_inc >= TRY_LIM)
                    w_exhaust = 1'b1;
            end
            CHECK: begin
                if (occ_ready) begin
                    if (!occ_hit) begin
                        w_food_x     = r_cand_x;
                        w_food_y     = r_cand_y;
                        w_food_valid = 1'b1;
                        w_state_nxt  = IDLE;
                    end else if (r_tries < TRY_LIM) begin
                        w_state_nxt = DRAW;
                    end else begin
                        w_exhaust = 1'b1;
                    end
                end
            end
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            SCAN: begin
                if (occ_ready) begin
                    if (!occ_hit) begin
                        w_food_x     = r_scan_x;
                        w_food_y     = r_scan_y;
                        w_food_valid = 1'b1;
                        w_state_nxt  = IDLE;
                    end else if (r_scan_x == X_LAST && r_scan_y == Y_LAST) begin
                        w_fail      = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_scan_x == X_LAST) begin
                        w_scan_x = '0;
                        w_scan_y = r_scan_y + 4'd1;
                    end else begin
                        w_scan_x = r_scan_x + 5'd1;
                    end
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase

        // Both exhaustion sources (hit on last try, out-of-range last draw) share one exit.
        if (w_exhaust) begin
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            w_state_nxt = SCAN;
            w_scan_x    = '0;
            w_scan_y    = '0;
`else
            w_state_nxt = IDLE;
            w_fail      = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_tries      <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_fail       <= 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            r_scan_x     <= '0;
            r_scan_y     <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cand_x     <= w_cand_x;
            r_cand_y     <= w_cand_y;
            r_tries      <= w_tries;
            r_food_x     <= w_food_x;
            r_food_y     <= w_food_y;
            r_food_valid <= w_food_valid;
            r_fail       <= w_fail;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
            r_scan_x     <= w_scan_x;
            r_scan_y     <= w_scan_y;
`endif
        end
    end

    assign busy       = (r_state != IDLE);
    assign rng_update = (r_state == DRAW);
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign fail       = r_fail;

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    assign occ_valid = (r_state == CHECK) || (r_state == SCAN);
    assign occ_x     = (r_state == SCAN) ? r_scan_x : r_cand_x;
    assign occ_y     = (r_state == SCAN) ? r_scan_y : r_cand_y;
`else
    assign occ_valid = (r_state == CHECK);
    assign occ_x     = r_cand_x;
    assign occ_y     = r_cand_y;
`endif

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: random source and occupancy are modelled by tables.
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       place_req;
    logic [3:0] rng4;
    logic [4:0] rng5;
    logic       rng_update;
    logic       occ_valid;
    logic [4:0] occ_x;
    logic [3:0] occ_y;
    logic       occ_ready;
    logic       occ_hit;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       fail;

    food_placer #(.GRID_W(20), .GRID_H(16), .MAX_TRIES(8)) dut (
        .clk(clk), .rst_n(rst_n), .place_req(place_req),
        .rng4(rng4), .rng5(rng5), .rng_update(rng_update),
        .occ_valid(occ_valid), .occ_x(occ_x), .occ_y(occ_y),
        .occ_ready(occ_ready), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .fail(fail)
    );

    always #5 clk = ~clk;

    logic [4:0] seq_x [16];
    logic [3:0] seq_y [16];
    logic       occ_map [32][16];
    int         base = 0;

    int n_upd = 0, n_q = 0, n_fail = 0, n_badq = 0;
    int u0, q0, b0;
    int errors = 0, checks = 0;

    // Random source steps once per rng_update edge; occupancy answers from the map.
    assign rng5    = seq_x[4'(n_upd - base)];
    assign rng4    = seq_y[4'(n_upd - base)];
    assign occ_hit = occ_map[occ_x][occ_y];

    always @(posedge clk) begin
        if (rng_update) n_upd <= n_upd + 1;
        if (occ_valid && occ_ready) n_q <= n_q + 1;
        if (occ_valid && occ_ready && occ_x >= 5'd20) n_badq <= n_badq + 1;
        if (fail) n_fail <= n_fail + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_table(input logic [4:0] x, input logic [3:0] y);
        for (int i = 0; i < 16; i++) begin
            seq_x[i] = x;
            seq_y[i] = y;
        end
    endtask

    task automatic fill_map(input logic v);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 16; j++)
                occ_map[i][j] = v;
    endtask

    task automatic snap();
        base = n_upd;
        u0   = n_upd;
        q0   = n_q;
        b0   = n_badq;
    endtask

    task automatic start();
        @(negedge clk) place_req = 1'b1;
        @(negedge clk) place_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; place_req = 1'b0; occ_ready = 1'b1;
        fill_table(5'd0, 4'd0);
        fill_map(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_food_x", food_x, 0);
        chk("rst_food_y", food_y, 0);
        chk("rst_food_valid", food_valid, 0);
        chk("rst_fail", fail, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occ_valid", occ_valid, 0);
        chk("rst_rng_update", rng_update, 0);
        rst_n = 1'b1;

        // First draw free: food after the second edge following the request edge.
        @(negedge clk);
        fill_table(5'd0, 4'd0);
        seq_x[0] = 5'd7; seq_y[0] = 4'd11;
        snap();
        start();
        chk("t1_busy", busy, 1);
        chk("t1_draw_upd", rng_update, 1);
        chk("t1_fv_e0", food_valid, 0);
        @(negedge clk);
        chk("t1_fv_e1", food_valid, 0);
        chk("t1_upd_e1", rng_update, 0);
        chk("t1_occ_valid", occ_valid, 1);
        chk("t1_occ_x", occ_x, 7);
        chk("t1_occ_y", occ_y, 11);
        @(negedge clk);
        chk("t1_fv_e2", food_valid, 1);
        chk("t1_food_x", food_x, 7);
        chk("t1_food_y", food_y, 11);
        chk("t1_busy_done", busy, 0);
        chk("t1_upd_cnt", n_upd - u0, 1);
        chk("t1_q_cnt", n_q - q0, 1);

        // First candidate occupied, second accepted.
        fill_map(1'b0);
        occ_map[7][11] = 1'b1;
        seq_x[0] = 5'd7;  seq_y[0] = 4'd11;
        seq_x[1] = 5'd15; seq_y[1] = 4'd6;
        snap();
        start();
        chk("t2_fv_cleared", food_valid, 0);
        wait_idle("t2_done");
        chk("t2_food_x", food_x, 15);
        chk("t2_food_y", food_y, 6);
        chk("t2_fv", food_valid, 1);
        chk("t2_upd_cnt", n_upd - u0, 2);
        chk("t2_q_cnt", n_q - q0, 2);

        // Out-of-range draw consumes a try without querying.
        fill_map(1'b0);
        seq_x[0] = 5'd25; seq_y[0] = 4'd3;
        seq_x[1] = 5'd4;  seq_y[1] = 4'd2;
        snap();
        start();
        wait_idle("t3_done");
        chk("t3_food_x", food_x, 4);
        chk("t3_food_y", food_y, 2);
        chk("t3_upd_cnt", n_upd - u0, 2);
        chk("t3_q_cnt", n_q - q0, 1);
        chk("t3_bad_q", n_badq - b0, 0);

        // Query held stable while unanswered, then reset mid-CHECK.
        occ_ready = 1'b0;
        seq_x[0] = 5'd3; seq_y[0] = 4'd5;
        snap();
        start();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", occ_valid, 1);
            chk("t4_hold_x", occ_x, 3);
            chk("t4_hold_y", occ_y, 5);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_occ_valid", occ_valid, 0);
        chk("t4_rst_fv", food_valid, 0);
        chk("t4_rst_upd", rng_update, 0);
        occ_ready = 1'b1;
        seq_x[0] = 5'd10; seq_y[0] = 4'd9;
        snap();
        start();
        wait_idle("t4_done");
        chk("t4_food_x", food_x, 10);
        chk("t4_food_y", food_y, 9);
        chk("t4_fv", food_valid, 1);

        // Request while busy is ignored.
        occ_ready = 1'b0;
        seq_x[0] = 5'd2; seq_y[0] = 4'd1;
        seq_x[1] = 5'd8; seq_y[1] = 4'd8;
        snap();
        start();
        start();
        occ_ready = 1'b1;
        wait_idle("t5_done");
        repeat (4) @(negedge clk);
        chk("t5_busy_after", busy, 0);
        chk("t5_upd_cnt", n_upd - u0, 1);
        chk("t5_food_x", food_x, 2);
        chk("t5_food_y", food_y, 1);

        // Every draw hits: exhaustion after MAX_TRIES draws.
        fill_map(1'b1);
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        occ_map[19][15] = 1'b0;
`endif
        fill_table(5'd5, 4'd5);
        snap();
        start();
        wait_idle("t6_done");
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        chk("t6_fail", fail, 0);
        chk("t6_fv", food_valid, 1);
        chk("t6_food_x", food_x, 19);
        chk("t6_food_y", food_y, 15);
        @(negedge clk);
        chk("t6_q_cnt", n_q - q0, 328);
`else
        chk("t6_fail", fail, 1);
        chk("t6_fv", food_valid, 0);
        @(negedge clk);
        chk("t6_fail_pulse", fail, 0);
        chk("t6_q_cnt", n_q - q0, 8);
`endif
        chk("t6_upd_cnt", n_upd - u0, 8);

        // Every draw out of range (x == GRID_W): exhaustion without any random query.
        fill_map(1'b0);
        fill_table(5'd20, 4'd0);
        snap();
        start();
        wait_idle("t7_done");
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
        chk("t7_fv", food_valid, 1);
        chk("t7_food_x", food_x, 0);
        chk("t7_food_y", food_y, 0);
        @(negedge clk);
        chk("t7_q_cnt", n_q - q0, 1);
`else
        chk("t7_fail", fail, 1);
        chk("t7_fv", food_valid, 0);
        @(negedge clk);
        chk("t7_fail_pulse", fail, 0);
        chk("t7_q_cnt", n_q - q0, 0);
`endif
        chk("t7_upd_cnt", n_upd - u0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
